// File: rtl/aoc_uart_floor_top.sv
// Floor counter driven by UART characters: '(' goes up, ')' goes down.
// The low byte of the counter is shown as two hex digits on active-low 7-segment displays.
module aoc_uart_floor_top #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned CNT_W        = 16
) (
    input  logic CLK,
    input  logic SW1,
    input  logic RX,
    output logic S1_A,
    output logic S1_B,
    output logic S1_C,
    output logic S1_D,
    output logic S1_E,
    output logic S1_F,
    output logic S1_G,
    output logic S2_A,
    output logic S2_B,
    output logic S2_C,
    output logic S2_D,
    output logic S2_E,
    output logic S2_F,
    output logic S2_G
);

    localparam int unsigned TMR_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [7:0]  CH_UP    = 8'h28;
    localparam logic [7:0]  CH_DOWN  = 8'h29;
    // Displays "0": segments A-F lit (low), G dark (high); bit order {G,F,E,D,C,B,A}
    localparam logic [6:0]  SEG_ZERO = 7'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_CLEANUP
    } state_t;

    logic             rx_meta;
    logic             rx_sync;
    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [7:0]       byte_q;
    logic [7:0]       byte_d;
    logic             byte_valid_q;
    logic             byte_valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       seg1_q;
    logic [6:0]       seg2_q;

    // Hex nibble to active-low segment pattern, bit order {G,F,E,D,C,B,A}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h39;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    // Two-flop synchronizer for the asynchronous RX line; resets to idle level
    always_ff @(posedge CLK) begin
        if (SW1) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    // UART receiver state and datapath registers
    always_ff @(posedge CLK) begin
        if (SW1) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // UART receiver next-state: verify start at mid-bit, then sample each bit at its centre
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rx_sync) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == TMR_W'(HALF_BIT - 1)) begin
                    timer_d = '0;
                    state_d = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == TMR_W'(CLKS_PER_BIT - 1)) begin
                    timer_d = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == TMR_W'(CLKS_PER_BIT - 1)) begin
                    timer_d = '0;
                    state_d = ST_CLEANUP;
                    // A low stop bit is a framing error; the byte is dropped
                    if (rx_sync) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CLEANUP: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Floor counter, wraps modulo 2^CNT_W
    always_ff @(posedge CLK) begin
        if (SW1) begin
            cnt_q <= '0;
        end else if (byte_valid_q) begin
            if (byte_q == CH_UP) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (byte_q == CH_DOWN) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Registered segment drivers for the counter's low byte
    always_ff @(posedge CLK) begin
        if (SW1) begin
            seg1_q <= SEG_ZERO;
            seg2_q <= SEG_ZERO;
        end else begin
            seg1_q <= hex_to_seg(cnt_q[7:4]);
            seg2_q <= hex_to_seg(cnt_q[3:0]);
        end
    end

    assign {S1_G, S1_F, S1_E, S1_D, S1_C, S1_B, S1_A} = seg1_q;
    assign {S2_G, S2_F, S2_E, S2_D, S2_C, S2_B, S2_A} = seg2_q;

endmodule

// File: tb/tb_aoc_uart_floor_top.sv
// Bench for the UART floor counter: frames are bit-banged on RX, expected digits queued and compared.
module tb_aoc_uart_floor_top;

    localparam int BIT_CLKS = 217;

    logic CLK;
    logic SW1;
    logic RX;
    logic S1_A, S1_B, S1_C, S1_D, S1_E, S1_F, S1_G;
    logic S2_A, S2_B, S2_C, S2_D, S2_E, S2_F, S2_G;
    logic [13:0] obs;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] model_cnt = '0;
    logic [13:0] exp_q[$];
    string font[16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                        "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

    aoc_uart_floor_top dut (
        .CLK  (CLK),
        .SW1  (SW1),
        .RX   (RX),
        .S1_A (S1_A), .S1_B (S1_B), .S1_C (S1_C), .S1_D (S1_D),
        .S1_E (S1_E), .S1_F (S1_F), .S1_G (S1_G),
        .S2_A (S2_A), .S2_B (S2_B), .S2_C (S2_C), .S2_D (S2_D),
        .S2_E (S2_E), .S2_F (S2_F), .S2_G (S2_G)
    );

    assign obs = {S1_G, S1_F, S1_E, S1_D, S1_C, S1_B, S1_A,
                  S2_G, S2_F, S2_E, S2_D, S2_C, S2_B, S2_A};

    initial CLK = 1'b0;
    always #20 CLK = ~CLK;

    // Active-low pattern {G..A} built from the list of lit segment letters
    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] lit;
        string s;
        int idx;
        lit = '0;
        s = font[nib];
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - 65;
            lit[idx] = 1'b1;
        end
        return ~lit;
    endfunction

    function automatic logic [13:0] disp_of(input logic [15:0] c);
        return {seg_of(c[7:4]), seg_of(c[3:0])};
    endfunction

    task automatic push_expected();
        exp_q.push_back(disp_of(model_cnt));
    endtask

    task automatic check_display(input string tag);
        logic [13:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic v);
        RX = v;
        wait_clks(BIT_CLKS);
    endtask

    // Pulse reset for 2 clocks, checking the display is "00" while it is held
    task automatic pulse_reset(input string tag);
        SW1 = 1'b1;
        wait_clks(2);
        model_cnt = '0;
        exp_q.delete();
        push_expected();
        check_display(tag);
        SW1 = 1'b0;
        wait_clks(2);
    endtask

    // Send one 8N1 frame, update the model, then compare the display
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap, input string tag);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
        end
        drive_bit(stop_ok);
        RX = 1'b1;
        if (stop_ok) begin
            if (b == 8'h28) begin
                model_cnt = model_cnt + 16'd1;
            end else if (b == 8'h29) begin
                model_cnt = model_cnt - 16'd1;
            end
        end
        push_expected();
        check_display(tag);
        wait_clks(gap);
    endtask

    initial begin
        logic [7:0] up_ch;
        up_ch = 8'h28;
        SW1 = 1'b1;
        RX  = 1'b1;
        wait_clks(2);
        push_expected();
        check_display("reset_00");
        SW1 = 1'b0;
        wait_clks(5);

        send_frame(8'h28, 1'b1, 10, "up_1");
        send_frame(8'h28, 1'b1, 10, "up_2");
        send_frame(8'h29, 1'b1, 10, "down_1");

        pulse_reset("reset_hold_a");
        send_frame(8'h29, 1'b1, 10, "down_to_FF");
        send_frame(8'h41, 1'b1, 10, "ignore_41");
        send_frame(8'h2A, 1'b1, 10, "ignore_2A");

        pulse_reset("reset_hold_b");
        send_frame(8'h28, 1'b0, 10, "framing_err");
        send_frame(8'h28, 1'b1, 10, "after_framing");

        // Short low glitch on RX must not start a frame
        RX = 1'b0;
        wait_clks(30);
        RX = 1'b1;
        wait_clks(300);
        push_expected();
        check_display("glitch");

        send_frame(8'h28, 1'b1, 0, "b2b_1");
        send_frame(8'h28, 1'b1, 0, "b2b_2");
        send_frame(8'h28, 1'b1, 0, "b2b_3");
        send_frame(8'h29, 1'b1, 10, "b2b_4");

        // Reset in the middle of the data bits of 0x28
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_bit(up_ch[i]);
        end
        RX = up_ch[3];
        pulse_reset("reset_midframe");
        RX = 1'b1;
        wait_clks(400);
        push_expected();
        check_display("after_midframe");
        send_frame(8'h28, 1'b1, 10, "resync_up");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
